bcd_display_mux: RTL and testbench
==================================

# bcd_display_mux

Two-digit multiplexed 7-segment display driver. It sits directly downstream of the BCD adder stage and consumes its two BCD result digits: `in0` is the units digit and `in1` is the tens digit. It time-multiplexes both digits onto one shared active-low segment bus with per-digit anode enables. New values are accepted through a valid/ready handshake and shown only at frame boundaries, so the display never tears.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit per slot. Legal range is 2 or more.
- `DIV_W`, default 16: width of the refresh counter. Must satisfy 2^DIV_W ≥ REFRESH_DIV.

Ports:
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in0`/`in1` carry a new result.
- `in_ready`  out  1: block can accept a value.
- `in0`  in  4: BCD units digit.
- `in1`  in  4: BCD tens digit.
- `seg_n`  out  7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an_n`  out  2: anode enables, active-low, registered. Bit 0 is the units digit, bit 1 is the tens digit.
- `frame_tick`  out  1: one-cycle pulse at each frame boundary, registered.

## Operation
Refresh counter and slot:
- `cnt` counts 0 to REFRESH_DIV-1, then wraps to 0.
- On each wrap, `slot` toggles. Slot 0 shows the units digit; slot 1 shows the tens digit.
- Frame boundary = the cycle where `cnt == REFRESH_DIV-1` and `slot == 1`.

Input path:
- Two registers: `pend` (pending value) and `shown` (displayed value).
- `in_ready = !pend_full`, driven combinationally from the register.
- Handshake (`in_valid && in_ready`): captures `in1`/`in0` into `pend` and sets `pend_full`.
- At a frame boundary with `pend_full` set: `shown <= pend`, and `pend_full` clears.
- A handshake on the frame-boundary cycle itself lands in `pend` and is displayed at the next boundary. There is no bypass.
- While `in_ready` is low, `in_valid` is ignored and the producer must hold its data.

Segment decode of the active digit (`seg_n` values):
- 0 → 1000000
- 1 → 1111001
- 2 → 0100100
- 3 → 0110000
- 4 → 0011001
- 5 → 0010010
- 6 → 0000010
- 7 → 1111000
- 8 → 0000000
- 9 → 0010000
- 10–15 (invalid BCD) → dash, 0111111

Anode outputs:
- `an_n` = 2'b10 in slot 0, 2'b01 in slot 1. It is never 2'b00.

Reset (asynchronous, any time, including mid-frame or with a value pending):
- `cnt` = 0, `slot` = 0.
- `shown` = 0/0, `pend_full` = 0, so `in_ready` = 1.
- `seg_n` = 7'h7F, `an_n` = 2'b11, `frame_tick` = 0.
- Any pending value is discarded.

## Timing
- `seg_n`, `an_n` and `frame_tick` are registered: each reflects `slot`/`shown` one cycle late.
- The first lit digit appears on the first clock edge after reset releases: units digit, showing 0.
- `frame_tick` is high during the cycle after the frame-boundary edge. In that same cycle, `an_n` switches to 2'b10 and shows the new units digit.
- Input-to-display latency:
  - Minimum: 2 cycles (capture on the boundary-minus-1 cycle).
  - Maximum: 2·REFRESH_DIV + 1 cycles.
- `in_ready` falls the cycle after a handshake and rises the cycle after the boundary that drains `pend`.

## Configuration
- `BCD_DISP_LZB_EN` defined: leading-zero blanking. When `shown` tens digit = 0, slot 1 drives `seg_n` = 7'h7F. `an_n` still cycles as normal, so frame timing is unchanged.
- Not defined: a tens digit of 0 displays as "0" (1000000).

## Structure
- Package `bcd_disp_pkg` holds:
  - the eleven segment-code constants (0–9, dash);
  - the blank code 7'h7F;
  - the slot encoding (SLOT_UNITS = 0, SLOT_TENS = 1);
  - the anode patterns.
- Sub-module `bcd_to_seg7`: purely combinational, 4-bit BCD in → 7-bit active-low segments out, invalid inputs → dash.
- The top level holds the counter, slot, `pend`/`shown` registers, output registers, and the optional blanking mux.

## Test plan
All scenarios use REFRESH_DIV = 4, giving a 4-cycle slot and an 8-cycle frame.
- Reset release, no input → `an_n` alternates 10/01 every 4 cycles. `seg_n` = 1000000 in both slots. `frame_tick` pulses every 8 cycles.
- Handshake `in1=4`, `in0=7` → `in_ready` low next cycle. After the next boundary: units slot `seg_n` = 1111000, tens slot `seg_n` = 0011001, and `in_ready` returns high.
- Second `in_valid` while `pend_full` → ignored. The displayed value is unchanged until the pending value drains, and the held value is then accepted.
- `in0=12` → units slot shows dash 0111111.
- `in1=0`, `in0=5`, with `BCD_DISP_LZB_EN` → tens slot `seg_n` = 7'h7F with `an_n` = 01. Without the macro → tens slot `seg_n` = 1000000.
- Assert `rst_n` mid-slot with a value pending → outputs go immediately to 7'h7F / 2'b11 / 0. After release, the display shows 0/0 and the pending value is lost.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// ----------------------------------------------------------------------------
// bcd_disp_pkg
// Shared constants for the two-digit multiplexed 7-segment display driver.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
// Contents:
//   SEG_0 .. SEG_9  digit glyphs
//   SEG_DASH        glyph shown for invalid BCD codes (10-15)
//   SEG_BLANK       all segments off
//   slot_t          which digit is lit (SLOT_UNITS / SLOT_TENS)
//   AN_*            active-low anode patterns (bit 0 units, bit 1 tens)
// ----------------------------------------------------------------------------
package bcd_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      SLOT_UNITS = 1'b0,
      SLOT_TENS  = 1'b1
   } slot_t;

   localparam logic [1:0] AN_UNITS = 2'b10;
   localparam logic [1:0] AN_TENS  = 2'b01;
   localparam logic [1:0] AN_OFF   = 2'b11;

endpackage

// File: rtl/bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd    in  4  BCD digit (10-15 are invalid)
//   seg_n  out 7  segments {g,f,e,d,c,b,a}, active-low; invalid codes give a dash
// ----------------------------------------------------------------------------
module bcd_to_seg7 (
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   import bcd_disp_pkg::*;

   // Straight table lookup; anything outside 0-9 shows a dash so a
   // misbehaving upstream adder is visible on the display rather than hidden.
   always_comb begin
      seg_n = SEG_DASH;
      case (bcd)
         4'd0: seg_n = SEG_0;
         4'd1: seg_n = SEG_1;
         4'd2: seg_n = SEG_2;
         4'd3: seg_n = SEG_3;
         4'd4: seg_n = SEG_4;
         4'd5: seg_n = SEG_5;
         4'd6: seg_n = SEG_6;
         4'd7: seg_n = SEG_7;
         4'd8: seg_n = SEG_8;
         4'd9: seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_mux.sv
// ----------------------------------------------------------------------------
// bcd_display_mux
// Two-digit multiplexed 7-segment display driver with a valid/ready input.
// New values wait in a pending register and only move to the displayed
// register at a frame boundary, so a frame never mixes two values.
// Parameters:
//   REFRESH_DIV  cycles each digit is lit per slot (>= 2)
//   DIV_W        refresh counter width, 2**DIV_W >= REFRESH_DIV
// Ports:
//   clk         in  1  clock
//   rst_n       in  1  asynchronous active-low reset
//   in_valid    in  1  in0/in1 carry a new result
//   in_ready    out 1  a new value can be accepted
//   in0         in  4  BCD units digit
//   in1         in  4  BCD tens digit
//   seg_n       out 7  active-low segments {g,f,e,d,c,b,a}, registered
//   an_n        out 2  active-low anodes, bit 0 units, bit 1 tens, registered
//   frame_tick  out 1  one-cycle pulse after each frame boundary, registered
// Build option:
//   BCD_DISP_LZB_EN  leading-zero blanking of a tens digit of 0
// ----------------------------------------------------------------------------
module bcd_display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int DIV_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   output logic [6:0] seg_n,
   output logic [1:0] an_n,
   output logic       frame_tick
);

   import bcd_disp_pkg::*;

   localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0] cnt;
   slot_t            slot;
   slot_t            slot_next;
   logic             wrap;
   logic             boundary;
   logic             handshake;

   logic [3:0]       pend_units;
   logic [3:0]       pend_tens;
   logic             pend_full;
   logic [3:0]       shown_units;
   logic [3:0]       shown_tens;
   logic [3:0]       shown_units_next;
   logic [3:0]       shown_tens_next;

   logic [3:0]       digit_next;
   logic [6:0]       dec_seg;
   logic [6:0]       seg_next;
   logic [1:0]       an_next;

   assign in_ready = !pend_full;

   // Slot timing and the frame boundary. The output registers are loaded
   // from the next-state values so that the lit digit, the anodes and the
   // displayed value all change on the same edge as slot/shown do; this is
   // what puts frame_tick, the switch to the units anode and the new units
   // digit in the same cycle.
   always_comb begin
      wrap             = (cnt == CNT_LAST);
      boundary         = wrap && (slot == SLOT_TENS);
      handshake        = in_valid && !pend_full;

      slot_next        = slot;
      if (wrap) begin
         slot_next = (slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
      end

      shown_units_next = shown_units;
      shown_tens_next  = shown_tens;
      if (boundary && pend_full) begin
         shown_units_next = pend_units;
         shown_tens_next  = pend_tens;
      end

      digit_next = (slot_next == SLOT_TENS) ? shown_tens_next : shown_units_next;
      an_next    = (slot_next == SLOT_TENS) ? AN_TENS : AN_UNITS;
   end

   bcd_to_seg7 u_dec (
      .bcd   (digit_next),
      .seg_n (dec_seg)
   );

   // Optional leading-zero blanking: the tens anode still cycles so the
   // frame timing is identical with or without it, only the glyph goes dark.
   always_comb begin
      seg_next = dec_seg;
`ifdef BCD_DISP_LZB_EN
      if ((slot_next == SLOT_TENS) && (shown_tens_next == 4'd0)) begin
         seg_next = SEG_BLANK;
      end
`else
      seg_next = dec_seg;
`endif
   end

   // Free-running refresh counter; each wrap hands the display to the
   // other digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         slot <= SLOT_UNITS;
      end else begin
         cnt  <= wrap ? '0 : cnt + DIV_W'(1);
         slot <= slot_next;
      end
   end

   // Input path. A handshake only happens while pend is empty, so capture
   // and drain can never collide; a value captured on the boundary cycle
   // itself waits a full frame for the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_units  <= 4'd0;
         pend_tens   <= 4'd0;
         pend_full   <= 1'b0;
         shown_units <= 4'd0;
         shown_tens  <= 4'd0;
      end else begin
         if (handshake) begin
            pend_units <= in0;
            pend_tens  <= in1;
            pend_full  <= 1'b1;
         end else if (boundary) begin
            pend_full  <= 1'b0;
         end
         shown_units <= shown_units_next;
         shown_tens  <= shown_tens_next;
      end
   end

   // Registered display outputs; everything is dark while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n      <= SEG_BLANK;
         an_n       <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         seg_n      <= seg_next;
         an_n       <= an_next;
         frame_tick <= boundary;
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// ----------------------------------------------------------------------------
// tb_bcd_display_mux
// Directed self-checking bench for bcd_display_mux with REFRESH_DIV = 4
// (4-cycle slot, 8-cycle frame). edge_n counts rising edges since the last
// reset release; after edge n the display reflects cnt = n % 4 and
// slot = (n / 4) % 2, and frame_tick is high when n is a nonzero multiple
// of 8. Expected tens-zero glyph depends on BCD_DISP_LZB_EN.
// ----------------------------------------------------------------------------
module tb_bcd_display_mux;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in0;
   logic [3:0] in1;
   logic [6:0] seg_n;
   logic [1:0] an_n;
   logic       frame_tick;

   int compared;
   int mismatched;
   int edge_n;

   localparam logic [6:0] E_BLANK = 7'h7F;
   localparam logic [6:0] E_ZERO  = 7'b1000000;
`ifdef BCD_DISP_LZB_EN
   localparam logic [6:0] E_TENS0 = 7'h7F;
`else
   localparam logic [6:0] E_TENS0 = 7'b1000000;
`endif

   bcd_display_mux #(
      .REFRESH_DIV (4),
      .DIV_W       (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in0        (in0),
      .in1        (in1),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .frame_tick (frame_tick)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive the producer side of the handshake.
   task automatic applyStimulus(input logic v, input logic [3:0] tens, input logic [3:0] units);
      in_valid = v;
      in1      = tens;
      in0      = units;
   endtask

   // Advance to rising edge number target (since reset release), settling 1 ns after it.
   task automatic goTo(input int target);
      while (edge_n < target) begin
         @(posedge clk);
         edge_n = edge_n + 1;
      end
      #1;
   endtask

   // Compare all four observable outputs against hand-computed values.
   task automatic checkOutput(input string tag, input logic [6:0] e_seg, input logic [1:0] e_an,
                              input logic e_ft, input logic e_rdy);
      compared = compared + 1;
      assert (seg_n === e_seg) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s seg_n observed=%b expected=%b", tag, seg_n, e_seg);
      end
      compared = compared + 1;
      assert (an_n === e_an) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s an_n observed=%b expected=%b", tag, an_n, e_an);
      end
      compared = compared + 1;
      assert (frame_tick === e_ft) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s frame_tick observed=%b expected=%b", tag, frame_tick, e_ft);
      end
      compared = compared + 1;
      assert (in_ready === e_rdy) else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s in_ready observed=%b expected=%b", tag, in_ready, e_rdy);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      edge_n     = 0;
      rst_n      = 1'b0;
      applyStimulus(1'b0, 4'd0, 4'd0);

      // Held in reset: everything dark, ready high.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset", E_BLANK, 2'b11, 1'b0, 1'b1);

      // Release between edges; idle display shows 0/0.
      rst_n  = 1'b1;
      edge_n = 0;
      goTo(1);  checkOutput("rel_units",  E_ZERO,  2'b10, 1'b0, 1'b1);
      goTo(3);  checkOutput("units_end",  E_ZERO,  2'b10, 1'b0, 1'b1);
      goTo(4);  checkOutput("tens_slot",  E_TENS0, 2'b01, 1'b0, 1'b1);
      goTo(7);  checkOutput("tens_end",   E_TENS0, 2'b01, 1'b0, 1'b1);
      goTo(8);  checkOutput("frame1",     E_ZERO,  2'b10, 1'b1, 1'b1);

      // Handshake 4/7, then a second value 2/3 held while not ready.
      goTo(9);  checkOutput("pre_hs",     E_ZERO,  2'b10, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd4, 4'd7);
      goTo(10); checkOutput("hs_rdy_low", E_ZERO,  2'b10, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 4'd3);
      goTo(12); checkOutput("old_tens",   E_TENS0, 2'b01, 1'b0, 1'b0);
      goTo(15); checkOutput("pre_drain",  E_TENS0, 2'b01, 1'b0, 1'b0);
      goTo(16); checkOutput("new_units",  7'b1111000, 2'b10, 1'b1, 1'b1);
      goTo(17); checkOutput("held_taken", 7'b1111000, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 4'd0);
      goTo(20); checkOutput("new_tens",   7'b0011001, 2'b01, 1'b0, 1'b0);
      goTo(24); checkOutput("held_units", 7'b0110000, 2'b10, 1'b1, 1'b1);
      goTo(28); checkOutput("held_tens",  7'b0100100, 2'b01, 1'b0, 1'b1);

      // Capture on boundary-minus-1 (minimum latency), invalid units digit.
      goTo(30);
      applyStimulus(1'b1, 4'd0, 4'd12);
      goTo(31); checkOutput("min_cap",    7'b0100100, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 4'd0);
      goTo(32); checkOutput("dash_units", 7'b0111111, 2'b10, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'd0, 4'd5);
      goTo(33); checkOutput("cap_05",     7'b0111111, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 4'd0);
      goTo(36); checkOutput("dash_tens0", E_TENS0, 2'b01, 1'b0, 1'b0);
      goTo(40); checkOutput("five_units", 7'b0010010, 2'b10, 1'b1, 1'b1);
      goTo(44); checkOutput("five_tens0", E_TENS0, 2'b01, 1'b0, 1'b1);

      // Leave 9/9 pending, then reset mid-slot.
      applyStimulus(1'b1, 4'd9, 4'd9);
      goTo(45); checkOutput("pend_99",    E_TENS0, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 4'd0);
      goTo(46);
      #2 rst_n = 1'b0;
      #2 checkOutput("async_rst", E_BLANK, 2'b11, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1 checkOutput("rst_hold",  E_BLANK, 2'b11, 1'b0, 1'b1);

      // After release the pending 9/9 must be gone.
      rst_n  = 1'b1;
      edge_n = 0;
      goTo(1);  checkOutput("rerel_units", E_ZERO,  2'b10, 1'b0, 1'b1);
      goTo(8);  checkOutput("rerel_frame", E_ZERO,  2'b10, 1'b1, 1'b1);
      goTo(12); checkOutput("rerel_tens",  E_TENS0, 2'b01, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
